tdm_demux_16ch_s4: RTL and testbench

- Receive-side partner of the 16:1 TDM multiplexer.
- Accepts a 1-bit-per-beat serial stream tagged with a 4-bit slot index and rebuilds the 16-bit parallel word.
- Checks slot ordering and presents each complete frame on a valid/ready output with one frame of buffering.
- Sits at the far end of a time-division link, between the line sampler and downstream parallel logic.

---
 rtl/mux_demux_pkg.sv | 14 +
 rtl/tdm_out_buf.sv | 45 ++++
 rtl/tdm_demux_16ch_s4.sv | 129 ++++++++++++
 tb/tb_tdm_demux_16ch_s4.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_demux_pkg.sv
// rtl/mux_demux_pkg.sv - constants and types shared by the TDM mux and demux
package mux_demux_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = $clog2(NUM_CH);

    typedef logic [SEL_W-1:0] slot_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_out_buf.sv
// rtl/tdm_out_buf.sv - one-entry valid/ready holding register for rebuilt frames
module tdm_out_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_overflow,
    output logic         o_drop
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         r_overflow;
    logic         w_free;

    // The slot is free when empty or being drained this very cycle.
    assign w_free = !r_valid || i_ready;
    assign o_drop = i_load && !w_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= o_drop;
            if (i_load && w_free) begin
                r_valid <= 1'b1;
                r_data  <= i_load_data;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/tdm_demux_16ch_s4.sv
// rtl/tdm_demux_16ch_s4.sv - 1:16 TDM demultiplexer with slot checking and one-frame output buffer
module tdm_demux_16ch_s4
    import mux_demux_pkg::*;
#(
    parameter int NUM_CH    = mux_demux_pkg::NUM_CH,
    parameter int SEL_W     = mux_demux_pkg::SEL_W,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_sof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_CH-1:0]    out_data,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    state_t                r_state;
    slot_t                 r_exp_ch;
    logic [NUM_CH-1:0]     r_shadow;
    logic                  r_frame_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    state_t                w_next_state;
    slot_t                 w_next_exp;
    slot_t                 w_wr_idx;
    logic                  w_we;
    logic                  w_ferr;
    logic                  w_complete;
    logic                  w_sof0;
    logic                  w_drop;
    logic [NUM_CH-1:0]     w_frame;
    logic [ERR_CNT_W:0]    w_err_sum;

    assign w_sof0 = in_sof && (in_sel == '0);

    always_comb begin
        w_next_state = r_state;
        w_next_exp   = r_exp_ch;
        w_wr_idx     = r_exp_ch;
        w_we         = 1'b0;
        w_ferr       = 1'b0;
        w_complete   = 1'b0;
        if (in_valid) begin
            case (r_state)
                IDLE: begin
                    if (w_sof0) begin
                        w_we         = 1'b1;
                        w_wr_idx     = '0;
                        w_next_exp   = slot_t'(1);
                        w_next_state = COLLECT;
                    end
                end
                COLLECT: begin
                    if (!in_sof && (in_sel == r_exp_ch)) begin
                        w_we = 1'b1;
                        if (r_exp_ch == slot_t'(NUM_CH - 1)) begin
                            w_complete   = 1'b1;
                            w_next_exp   = '0;
                            w_next_state = IDLE;
                        end else begin
                            w_next_exp = r_exp_ch + 1'b1;
                        end
                    end else if (w_sof0) begin
                        // Early start-of-frame: resynchronise onto the new frame.
                        w_ferr     = 1'b1;
                        w_we       = 1'b1;
                        w_wr_idx   = '0;
                        w_next_exp = slot_t'(1);
                    end else begin
                        w_ferr       = 1'b1;
                        w_next_exp   = '0;
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // The final bit rides straight into the buffer alongside the shadow contents.
    always_comb begin
        w_frame             = r_shadow;
        w_frame[NUM_CH-1]   = in_data;
    end

    assign w_err_sum = {1'b0, r_err_cnt} + (ERR_CNT_W+1)'(w_ferr) + (ERR_CNT_W+1)'(w_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_exp_ch    <= '0;
            r_shadow    <= '0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_exp_ch    <= w_next_exp;
            r_frame_err <= w_ferr;
            if (w_we) begin
                r_shadow[w_wr_idx] <= in_data;
            end
            r_err_cnt <= w_err_sum[ERR_CNT_W] ? '1 : w_err_sum[ERR_CNT_W-1:0];
        end
    end

    tdm_out_buf #(
        .W (NUM_CH)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_complete),
        .i_load_data (w_frame),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_overflow  (overflow),
        .o_drop      (w_drop)
    );

    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_tdm_demux_16ch_s4.sv
// tb/tb_tdm_demux_16ch_s4.sv - self-checking bench for tdm_demux_16ch_s4
module tb_tdm_demux_16ch_s4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_data;
    logic [3:0]  in_sel;
    logic        in_sof;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        frame_err;
    logic        overflow;
    logic [7:0]  err_cnt;

    int total;
    int bad;

    // Reference: expected next slot (-1 when hunting for a start), collected bits, held frame.
    int          m_next;
    bit [15:0]   m_bits;
    bit          m_vld;
    bit [15:0]   m_data;
    int          m_err;
    bit          m_ferr;
    bit          m_ovf;

    typedef struct {
        logic [15:0] word;
        logic        rdy;
        logic        rdy_last;
        int          bad_at;
        logic        drain;
        logic        exp_valid;
        logic [15:0] exp_data;
        int          exp_err;
    } vec_t;

    vec_t vecs[7];

    tdm_demux_16ch_s4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next = -1;
        m_bits = '0;
        m_vld  = 0;
        m_data = '0;
        m_err  = 0;
        m_ferr = 0;
        m_ovf  = 0;
    endtask

    task automatic model_edge(input bit v, input bit d, input int sel, input bit sof, input bit rdy);
        bit done;
        bit drain;
        done   = 0;
        m_ferr = 0;
        m_ovf  = 0;
        drain  = m_vld && rdy;
        if (v) begin
            if (m_next < 0) begin
                if (sof && sel == 0) begin
                    m_bits[0] = d;
                    m_next    = 1;
                end
            end else if (!sof && sel == m_next) begin
                m_bits[sel] = d;
                if (sel == 15) begin
                    done   = 1;
                    m_next = -1;
                end else begin
                    m_next = m_next + 1;
                end
            end else if (sof && sel == 0) begin
                m_ferr    = 1;
                m_bits[0] = d;
                m_next    = 1;
            end else begin
                m_ferr = 1;
                m_next = -1;
            end
        end
        if (done) begin
            if (!m_vld || drain) begin
                m_vld  = 1;
                m_data = m_bits;
            end else begin
                m_ovf = 1;
            end
        end else if (drain) begin
            m_vld = 0;
        end
        m_err = m_err + int'(m_ferr) + int'(m_ovf);
        if (m_err > 255) m_err = 255;
    endtask

    task automatic step(input logic v, input logic d, input int sel, input logic sof, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_sel    = 4'(sel);
        in_sof    = sof;
        out_ready = rdy;
        @(posedge clk);
        model_edge(v, d, sel, sof, rdy);
        #1;
        chk("out_valid", 16'(out_valid), 16'(m_vld));
        chk("out_data", out_data, m_data);
        chk("frame_err", 16'(frame_err), 16'(m_ferr));
        chk("overflow", 16'(overflow), 16'(m_ovf));
        chk("err_cnt", 16'(err_cnt), 16'(m_err));
    endtask

    task automatic send_frame(input logic [15:0] word, input logic rdy, input logic rdy_last,
                              input int bad_at, input logic drain);
        if (drain) step(0, 0, 0, 0, 1);
        for (int s = 0; s < 16; s++) begin
            if (s == bad_at) begin
                step(1, word[s], s + 1, 0, rdy);
                return;
            end
            step(1, word[s], s, s == 0, (s == 15) ? rdy_last : rdy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();

        //          word      rdy   rdyL  bad drain  expV  expD      err
        vecs[0] = '{16'hA5C3, 1'b1, 1'b1, -1, 1'b1, 1'b1, 16'hA5C3, 0};
        vecs[1] = '{16'h1234, 1'b0, 1'b0, -1, 1'b1, 1'b1, 16'h1234, 0};
        vecs[2] = '{16'hFFFF, 1'b0, 1'b0, -1, 1'b0, 1'b1, 16'h1234, 1};
        vecs[3] = '{16'h0000, 1'b0, 1'b0,  5, 1'b0, 1'b1, 16'h1234, 2};
        vecs[4] = '{16'h00FF, 1'b1, 1'b1, -1, 1'b1, 1'b1, 16'h00FF, 2};
        vecs[5] = '{16'h5555, 1'b1, 1'b1, -1, 1'b1, 1'b1, 16'h5555, 2};
        vecs[6] = '{16'hAAAA, 1'b0, 1'b1, -1, 1'b0, 1'b1, 16'hAAAA, 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 1'b0;
        in_sel    = '0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_frame_err", 16'(frame_err), 16'h0);
        chk("rst_overflow", 16'(overflow), 16'h0);
        chk("rst_err_cnt", 16'(err_cnt), 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].word, vecs[i].rdy, vecs[i].rdy_last, vecs[i].bad_at, vecs[i].drain);
            chk("vec_valid", 16'(out_valid), 16'(vecs[i].exp_valid));
            chk("vec_data", out_data, vecs[i].exp_data);
            chk("vec_err", 16'(err_cnt), 16'(vecs[i].exp_err));
        end

        // Drain AAAA with nothing completing: valid must fall.
        step(0, 0, 0, 0, 1);
        chk("drain_fall", 16'(out_valid), 16'h0);

        // Re-sync: sof arrives after slot 7 of a partial frame.
        for (int s = 0; s < 8; s++) step(1, 1'b1, s, s == 0, 1);
        in_valid  = 1'b1;
        in_data   = 1'b1;
        in_sel    = 4'd0;
        in_sof    = 1'b1;
        step(1, 1'b1, 0, 1, 1);
        chk("resync_ferr", 16'(frame_err), 16'h1);
        for (int s = 1; s < 16; s++) step(1, (s == 15), s, 0, 1);
        chk("resync_valid", 16'(out_valid), 16'h1);
        chk("resync_data", out_data, 16'h8001);
        chk("resync_err", 16'(err_cnt), 16'd3);

        // Async reset mid-frame with a frame held.
        for (int s = 0; s < 5; s++) step(1, 1'b0, s, s == 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 16'(out_valid), 16'h0);
        chk("async_data", out_data, 16'h0);
        chk("async_err", 16'(err_cnt), 16'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Remaining beats of the interrupted frame must be ignored.
        for (int s = 5; s < 16; s++) step(1, 1'b1, s, 0, 1);
        chk("post_rst_valid", 16'(out_valid), 16'h0);

        // Randomised traffic biased toward well-formed frames.
        for (int n = 0; n < 1500; n++) begin
            int sel;
            bit v;
            v   = ($urandom_range(0, 9) != 0);
            sel = (m_next < 0) ? 0 : m_next;
            if ($urandom_range(0, 19) == 0) sel = $urandom_range(0, 15);
            step(v, 1'($urandom), sel, (sel == 0) && ($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 3) != 0));
        end

        // Saturation: 300 slot errors.
        for (int n = 0; n < 300; n++) begin
            step(1, 0, 0, 1, 1);
            step(1, 0, 9, 0, 1);
        end
        chk("sat_err_cnt", 16'(err_cnt), 16'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
